// File: rtl/adpll_pkg.sv
// Shared definitions for the ADPLL lock monitor: 2-bit lock-state encodings
// and the saturating absolute-value helper used on the signed phase error.
package adpll_pkg;

   localparam logic [1:0] LOCK_UNLOCKED = 2'd0;
   localparam logic [1:0] LOCK_ACQUIRE  = 2'd1;
   localparam logic [1:0] LOCK_LOCKED   = 2'd2;
   localparam logic [1:0] LOCK_SLIP     = 2'd3;

   // |v| for a width-bit signed value; the most negative code maps to the largest positive one
   function automatic int abs_sat(input int v, input int width);
      int lim;
      lim = (1 << (width - 1)) - 1;
      if (v < -lim)
         return lim;
      else if (v < 0)
         return -v;
      else
         return v;
   endfunction

endpackage

// File: rtl/adpll_edge_sync.sv
// Two-flop synchroniser plus edge flop for an asynchronous level; emits a
// one-cycle strobe on each rising edge. Reusable by the phase detectors.
module adpll_edge_sync (
   input  logic clk_i,
   input  logic reset_i,
   input  logic async_i,
   output logic strobe_o
);

   logic s1_q, s2_q, s3_q;
   logic s1_d, s2_d, s3_d;

   always_comb begin
      s1_d = async_i;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign strobe_o = s2_q & ~s3_q;

endmodule

// File: rtl/adpll_lock_detector.sv
// Lock monitor for one ring ADPLL node: samples error/DCO code on each divided-clock
// edge and tracks UNLOCKED/ACQUIRE/LOCKED/SLIP. ADPLL_LOCK_STATS_EN builds the slip counter.
module adpll_lock_detector
   import adpll_pkg::*;
#(
   parameter int PDET_WIDTH     = 5,
   parameter int RO_WIDTH       = 5,
   parameter int ERR_TOL        = 2,
   parameter int CC_TOL         = 2,
   parameter int LOCK_COUNT     = 16,
   parameter int UNLOCK_COUNT   = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int SLIP_CNT_WIDTH = 8
) (
   input  logic                         fpga_clk_i,
   input  logic                         reset_i,
   input  logic                         enable_i,
   input  logic                         gen_div_i,
   input  logic signed [PDET_WIDTH-1:0] error_i,
   input  logic signed [RO_WIDTH-1:0]   dco_cc_i,
   output logic                         lock_o,
   output logic [1:0]                   state_o,
   output logic [RO_WIDTH:0]            cc_span_o,
   output logic                         stall_o,
   output logic [SLIP_CNT_WIDTH-1:0]    slip_count_o
);

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int BW = $clog2(UNLOCK_COUNT + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [GW-1:0]     LOCK_L   = GW'(LOCK_COUNT);
   localparam logic [BW-1:0]     UNLOCK_L = BW'(UNLOCK_COUNT);
   localparam logic [TW-1:0]     TMO_L    = TW'(TIMEOUT_CYCLES);
   localparam logic [RO_WIDTH:0] CC_TOL_L = (RO_WIDTH + 1)'(CC_TOL);

   logic strobe;

   logic                         sample_vld_q, sample_vld_d;
   logic signed [PDET_WIDTH-1:0] err_q, err_d;
   logic signed [RO_WIDTH-1:0]   cc_q, cc_d;
   logic [1:0]                   state_q, state_d;
   logic                         lock_q, lock_d;
   logic                         stall_q, stall_d;
   logic [GW-1:0]                good_cnt_q, good_cnt_d;
   logic [BW-1:0]                bad_cnt_q, bad_cnt_d;
   logic [TW-1:0]                tmo_cnt_q, tmo_cnt_d;
   logic signed [RO_WIDTH-1:0]   cc_min_q, cc_min_d;
   logic signed [RO_WIDTH-1:0]   cc_max_q, cc_max_d;
   logic [RO_WIDTH:0]            cc_span_q, cc_span_d;

   logic                         good;
   logic                         tmo_hit;
   logic [GW-1:0]                good_inc;
   logic [BW-1:0]                bad_inc;
   logic signed [RO_WIDTH-1:0]   win_min, win_max;
   logic [RO_WIDTH:0]            win_span;

   adpll_edge_sync u_gen_div_sync (
      .clk_i    (fpga_clk_i),
      .reset_i  (reset_i),
      .async_i  (gen_div_i),
      .strobe_o (strobe)
   );

   always_comb begin
      sample_vld_d = strobe;
      err_d        = err_q;
      cc_d         = cc_q;
      if (strobe) begin
         err_d = error_i;
         cc_d  = dco_cc_i;
      end

      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      bad_cnt_d  = bad_cnt_q;
      cc_min_d   = cc_min_q;
      cc_max_d   = cc_max_q;

      good     = abs_sat(int'(err_q), PDET_WIDTH) <= ERR_TOL;
      good_inc = good_cnt_q + GW'(1);
      bad_inc  = bad_cnt_q + BW'(1);
      win_min  = (cc_q < cc_min_q) ? cc_q : cc_min_q;
      win_max  = (cc_q > cc_max_q) ? cc_q : cc_max_q;
      win_span = {win_max[RO_WIDTH-1], win_max} - {win_min[RO_WIDTH-1], win_min};

      // A strobe in the same cycle pre-empts the timeout
      tmo_hit   = !strobe && (tmo_cnt_q == TMO_L - TW'(1));
      tmo_cnt_d = tmo_cnt_q;
      if (strobe)
         tmo_cnt_d = '0;
      else if (tmo_cnt_q != TMO_L)
         tmo_cnt_d = tmo_cnt_q + TW'(1);

      stall_d = stall_q;
      if (strobe)
         stall_d = 1'b0;
      else if (tmo_hit)
         stall_d = 1'b1;

      if (state_q == LOCK_SLIP) begin
         state_d    = LOCK_UNLOCKED;
         good_cnt_d = '0;
         bad_cnt_d  = '0;
         cc_min_d   = '0;
         cc_max_d   = '0;
      end else if (tmo_hit) begin
         state_d    = (state_q == LOCK_LOCKED) ? LOCK_SLIP : LOCK_UNLOCKED;
         good_cnt_d = '0;
         bad_cnt_d  = '0;
         cc_min_d   = '0;
         cc_max_d   = '0;
      end else if (sample_vld_q) begin
         case (state_q)
            LOCK_UNLOCKED: begin
               if (good) begin
                  state_d    = LOCK_ACQUIRE;
                  good_cnt_d = GW'(1);
                  cc_min_d   = cc_q;
                  cc_max_d   = cc_q;
               end
            end
            LOCK_ACQUIRE: begin
               if (!good) begin
                  state_d    = LOCK_UNLOCKED;
                  good_cnt_d = '0;
                  cc_min_d   = '0;
                  cc_max_d   = '0;
               end else if (win_span > CC_TOL_L) begin
                  good_cnt_d = GW'(1);
                  cc_min_d   = cc_q;
                  cc_max_d   = cc_q;
               end else begin
                  good_cnt_d = good_inc;
                  cc_min_d   = win_min;
                  cc_max_d   = win_max;
                  if (good_inc == LOCK_L)
                     state_d = LOCK_LOCKED;
               end
            end
            LOCK_LOCKED: begin
               if (good) begin
                  bad_cnt_d = '0;
               end else begin
                  bad_cnt_d = bad_inc;
                  if (bad_inc == UNLOCK_L)
                     state_d = LOCK_SLIP;
               end
            end
            default: state_d = LOCK_UNLOCKED;
         endcase
      end

      // Disabled: hold everything idle but let the synchroniser keep tracking gen_div_i
      if (!enable_i) begin
         sample_vld_d = 1'b0;
         state_d      = LOCK_UNLOCKED;
         good_cnt_d   = '0;
         bad_cnt_d    = '0;
         tmo_cnt_d    = '0;
         stall_d      = 1'b0;
         cc_min_d     = '0;
         cc_max_d     = '0;
      end

      lock_d    = (state_d == LOCK_LOCKED);
      cc_span_d = {cc_max_d[RO_WIDTH-1], cc_max_d} - {cc_min_d[RO_WIDTH-1], cc_min_d};
   end

   always_ff @(posedge fpga_clk_i) begin
      if (reset_i) begin
         sample_vld_q <= 1'b0;
         err_q        <= '0;
         cc_q         <= '0;
         state_q      <= LOCK_UNLOCKED;
         lock_q       <= 1'b0;
         stall_q      <= 1'b0;
         good_cnt_q   <= '0;
         bad_cnt_q    <= '0;
         tmo_cnt_q    <= '0;
         cc_min_q     <= '0;
         cc_max_q     <= '0;
         cc_span_q    <= '0;
      end else begin
         sample_vld_q <= sample_vld_d;
         err_q        <= err_d;
         cc_q         <= cc_d;
         state_q      <= state_d;
         lock_q       <= lock_d;
         stall_q      <= stall_d;
         good_cnt_q   <= good_cnt_d;
         bad_cnt_q    <= bad_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         cc_min_q     <= cc_min_d;
         cc_max_q     <= cc_max_d;
         cc_span_q    <= cc_span_d;
      end
   end

`ifdef ADPLL_LOCK_STATS_EN
   logic [SLIP_CNT_WIDTH-1:0] slip_cnt_q, slip_cnt_d;

   always_comb begin
      slip_cnt_d = slip_cnt_q;
      if (state_d == LOCK_SLIP && state_q != LOCK_SLIP && slip_cnt_q != '1)
         slip_cnt_d = slip_cnt_q + SLIP_CNT_WIDTH'(1);
   end

   always_ff @(posedge fpga_clk_i) begin
      if (reset_i)
         slip_cnt_q <= '0;
      else
         slip_cnt_q <= slip_cnt_d;
   end

   assign slip_count_o = slip_cnt_q;
`else
   assign slip_count_o = '0;
`endif

   assign lock_o    = lock_q;
   assign state_o   = state_q;
   assign cc_span_o = cc_span_q;
   assign stall_o   = stall_q;

endmodule

// File: tb/tb_adpll_lock_detector.sv
// Self-checking bench for adpll_lock_detector; the reference model works on whole
// samples with a queue holding the acquisition window.
module tb_adpll_lock_detector;

   localparam int PW   = 5;
   localparam int RW   = 5;
   localparam int ETOL = 2;
   localparam int CTOL = 2;
   localparam int LCNT = 16;
   localparam int UCNT = 4;
   localparam int TMO  = 1024;
   localparam int SW   = 8;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic          enable_i = 1'b0;
   logic          gen_div_i = 1'b0;
   logic [PW-1:0] error_i = '0;
   logic [RW-1:0] dco_cc_i = '0;
   logic          lock_o;
   logic [1:0]    state_o;
   logic [RW:0]   cc_span_o;
   logic          stall_o;
   logic [SW-1:0] slip_count_o;

   int tests_run = 0;
   int tests_failed = 0;
   int slip_cycles = 0;

   // reference model state
   int m_state;
   int m_good;
   int m_bad;
   int m_slips;
   int m_win[$];

   adpll_lock_detector #(
      .PDET_WIDTH    (PW),
      .RO_WIDTH      (RW),
      .ERR_TOL       (ETOL),
      .CC_TOL        (CTOL),
      .LOCK_COUNT    (LCNT),
      .UNLOCK_COUNT  (UCNT),
      .TIMEOUT_CYCLES(TMO),
      .SLIP_CNT_WIDTH(SW)
   ) dut (
      .fpga_clk_i  (clk),
      .reset_i     (reset_i),
      .enable_i    (enable_i),
      .gen_div_i   (gen_div_i),
      .error_i     (error_i),
      .dco_cc_i    (dco_cc_i),
      .lock_o      (lock_o),
      .state_o     (state_o),
      .cc_span_o   (cc_span_o),
      .stall_o     (stall_o),
      .slip_count_o(slip_count_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (state_o == 2'd3) slip_cycles++;

   function automatic int m_abs(input int e);
      if (e == -(2 ** (PW - 1))) return 2 ** (PW - 1) - 1;
      return (e < 0) ? -e : e;
   endfunction

   function automatic int m_span();
      int lo, hi;
      if (m_win.size() == 0) return 0;
      lo = m_win[0];
      hi = m_win[0];
      foreach (m_win[i]) begin
         if (m_win[i] < lo) lo = m_win[i];
         if (m_win[i] > hi) hi = m_win[i];
      end
      return hi - lo;
   endfunction

   function automatic int exp_slips();
`ifdef ADPLL_LOCK_STATS_EN
      return (m_slips > 255) ? 255 : m_slips;
`else
      return 0;
`endif
   endfunction

   task automatic m_unlock();
      m_state = 0;
      m_good  = 0;
      m_bad   = 0;
      m_win.delete();
   endtask

   task automatic m_sample(input int e, input int cc);
      bit ok;
      ok = m_abs(e) <= ETOL;
      if (m_state == 0) begin
         if (ok) begin
            m_state = 1;
            m_good  = 1;
            m_win.delete();
            m_win.push_back(cc);
         end
      end else if (m_state == 1) begin
         if (!ok) begin
            m_unlock();
         end else begin
            m_win.push_back(cc);
            if (m_span() > CTOL) begin
               m_win.delete();
               m_win.push_back(cc);
               m_good = 1;
            end else begin
               m_good++;
               if (m_good == LCNT) m_state = 2;
            end
         end
      end else if (m_state == 2) begin
         if (ok) begin
            m_bad = 0;
         end else begin
            m_bad++;
            if (m_bad == UCNT) begin
               m_slips++;
               m_unlock();
            end
         end
      end
   endtask

   // one full divided-clock period: 6 cycles high, 3 low, then fold into the model
   task automatic send_sample(input int e, input int cc);
      @(negedge clk);
      error_i   = e[PW-1:0];
      dco_cc_i  = cc[RW-1:0];
      gen_div_i = 1'b1;
      repeat (6) @(negedge clk);
      gen_div_i = 1'b0;
      repeat (3) @(negedge clk);
      m_sample(e, cc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_i   = 1'b1;
      enable_i  = 1'b1;
      gen_div_i = 1'b0;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      m_unlock();
      m_slips = 0;
   endtask

   task automatic get_locked();
      for (int i = 0; i < LCNT; i++) send_sample(0, 3);
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++;
      if (state_o !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d want 0", state_o); end
      tests_run++;
      if (lock_o !== 1'b0) begin tests_failed++; $display("FAIL reset_lock got %0b want 0", lock_o); end
      tests_run++;
      if (cc_span_o !== '0) begin tests_failed++; $display("FAIL reset_span got %0d want 0", cc_span_o); end
      tests_run++;
      if (stall_o !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %0b want 0", stall_o); end
      tests_run++;
      if (slip_count_o !== '0) begin tests_failed++; $display("FAIL reset_slips got %0d want 0", slip_count_o); end
      // reset in the middle of an acquisition window
      for (int i = 0; i < 3; i++) send_sample(0, 1);
      @(negedge clk);
      reset_i = 1'b1;
      @(negedge clk);
      tests_run++;
      if (state_o !== 2'd0 || cc_span_o !== '0) begin
         tests_failed++;
         $display("FAIL reset_mid_window got state=%0d span=%0d want 0 0", state_o, cc_span_o);
      end
      reset_i = 1'b0;
   endtask

   task automatic test_lock_acquire();
      int n;
      do_reset();
      @(negedge clk);
      error_i   = '0;
      dco_cc_i  = 5'd3;
      gen_div_i = 1'b1;
      n = 0;
      while (state_o == 2'd0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (n < 4 || n > 5) begin tests_failed++; $display("FAIL sample_latency got %0d cycles want 4..5", n); end
      tests_run++;
      if (state_o !== 2'd1) begin tests_failed++; $display("FAIL first_sample_state got %0d want 1", state_o); end
      if (n < 6) repeat (6 - n) @(negedge clk);
      gen_div_i = 1'b0;
      repeat (3) @(negedge clk);
      m_sample(0, 3);
      for (int i = 1; i < LCNT - 1; i++) send_sample(0, 3);
      tests_run++;
      if (state_o !== 2'd1 || lock_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL lock_after_15 got state=%0d lock=%0b want 1 0", state_o, lock_o);
      end
      send_sample(0, 3);
      tests_run++;
      if (state_o !== 2'd2 || lock_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL lock_after_16 got state=%0d lock=%0b want 2 1", state_o, lock_o);
      end
      tests_run++;
      if (cc_span_o !== '0) begin tests_failed++; $display("FAIL lock_span got %0d want 0", cc_span_o); end
   endtask

   task automatic test_glitch_tolerance();
      do_reset();
      get_locked();
      send_sample(5, 3);
      send_sample(0, 3);
      tests_run++;
      if (state_o !== 2'd2 || lock_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_glitch got state=%0d lock=%0b want 2 1", state_o, lock_o);
      end
      // 3 bad, 1 good, 3 bad: survives only if the bad count restarts on a good sample
      for (int i = 0; i < 3; i++) send_sample(-4, 3);
      send_sample(0, 3);
      for (int i = 0; i < 3; i++) send_sample(-4, 3);
      tests_run++;
      if (state_o !== 2'd2 || lock_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL bad_cnt_clear got state=%0d lock=%0b want 2 1", state_o, lock_o);
      end
   endtask

   task automatic test_slip();
      int s0, want;
      do_reset();
      get_locked();
      s0 = slip_cycles;
      for (int i = 0; i < 3; i++) send_sample(-4, 3);
      tests_run++;
      if (state_o !== 2'd2) begin tests_failed++; $display("FAIL slip_after_3 got %0d want 2", state_o); end
      send_sample(-4, 3);
      tests_run++;
      if (slip_cycles - s0 != 1) begin
         tests_failed++;
         $display("FAIL slip_width got %0d cycles want 1", slip_cycles - s0);
      end
      tests_run++;
      if (state_o !== 2'd0 || lock_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL slip_then_unlocked got state=%0d lock=%0b want 0 0", state_o, lock_o);
      end
`ifdef ADPLL_LOCK_STATS_EN
      want = 1;
`else
      want = 0;
`endif
      tests_run++;
      if (int'(slip_count_o) != want) begin
         tests_failed++;
         $display("FAIL slip_count got %0d want %0d", slip_count_o, want);
      end
   endtask

   task automatic test_window_restart();
      int n;
      do_reset();
      send_sample(0, 0);
      send_sample(0, 1);
      send_sample(0, 2);
      tests_run++;
      if (state_o !== 2'd1 || cc_span_o !== 6'd2) begin
         tests_failed++;
         $display("FAIL window_span2 got state=%0d span=%0d want 1 2", state_o, cc_span_o);
      end
      send_sample(0, 3);
      tests_run++;
      if (state_o !== 2'd1 || cc_span_o !== 6'd0) begin
         tests_failed++;
         $display("FAIL window_restart got state=%0d span=%0d want 1 0", state_o, cc_span_o);
      end
      n = 4;
      while (state_o != 2'd2 && n < 30) begin
         send_sample(0, 3);
         n++;
      end
      tests_run++;
      if (n != LCNT + 3) begin tests_failed++; $display("FAIL restart_lock_delay got %0d samples want %0d", n, LCNT + 3); end
   endtask

   task automatic test_timeout();
      int n, s0;
      do_reset();
      get_locked();
      s0 = slip_cycles;
      @(negedge clk);
      error_i   = '0;
      dco_cc_i  = 5'd3;
      gen_div_i = 1'b1;
      n = 0;
      while (stall_o !== 1'b1 && n < 1200) begin
         @(negedge clk);
         n++;
         if (n == 6) gen_div_i = 1'b0;
      end
      m_sample(0, 3);
      tests_run++;
      if (n != TMO + 3) begin tests_failed++; $display("FAIL timeout_cycle got %0d want %0d", n, TMO + 3); end
      tests_run++;
      if (state_o !== 2'd3) begin tests_failed++; $display("FAIL timeout_slip got %0d want 3", state_o); end
      if (m_state == 2) m_slips++;
      m_unlock();
      repeat (2) @(negedge clk);
      tests_run++;
      if (state_o !== 2'd0 || stall_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL timeout_after got state=%0d stall=%0b want 0 1", state_o, stall_o);
      end
      tests_run++;
      if (slip_cycles - s0 != 1) begin tests_failed++; $display("FAIL timeout_slip_width got %0d want 1", slip_cycles - s0); end
      tests_run++;
      if (int'(slip_count_o) != exp_slips()) begin
         tests_failed++;
         $display("FAIL timeout_slip_count got %0d want %0d", slip_count_o, exp_slips());
      end
      send_sample(0, 3);
      tests_run++;
      if (stall_o !== 1'b0 || state_o !== 2'd1) begin
         tests_failed++;
         $display("FAIL stall_clear got stall=%0b state=%0d want 0 1", stall_o, state_o);
      end
   endtask

   task automatic test_saturation_enable();
      do_reset();
      send_sample(-16, 0);
      tests_run++;
      if (state_o !== 2'd0) begin tests_failed++; $display("FAIL abs_saturate got %0d want 0", state_o); end
      send_sample(3, 0);
      tests_run++;
      if (state_o !== 2'd0) begin tests_failed++; $display("FAIL err_tol_plus1 got %0d want 0", state_o); end
      send_sample(-2, 0);
      send_sample(2, 0);
      tests_run++;
      if (state_o !== 2'd1) begin tests_failed++; $display("FAIL err_tol_edge got %0d want 1", state_o); end
      @(negedge clk);
      enable_i = 1'b0;
      @(negedge clk);
      tests_run++;
      if (state_o !== 2'd0 || lock_o !== 1'b0 || stall_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL disable_acquire got state=%0d lock=%0b stall=%0b want 0 0 0", state_o, lock_o, stall_o);
      end
      m_unlock();
      send_sample(0, 0);
      tests_run++;
      if (state_o !== 2'd0) begin tests_failed++; $display("FAIL disabled_ignores got %0d want 0", state_o); end
      m_unlock();
      enable_i = 1'b1;
      send_sample(0, 0);
      tests_run++;
      if (state_o !== 2'd1) begin tests_failed++; $display("FAIL reenable got %0d want 1", state_o); end
   endtask

   task automatic test_random();
      int e, cc, base;
      do_reset();
      base = 0;
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 19) < 19) e = int'($urandom_range(0, 4)) - 2;
         else e = int'($urandom_range(0, 31)) - 16;
         if ($urandom_range(0, 9) == 0) base = int'($urandom_range(0, 20)) - 10;
         cc = base + (($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : 0);
         send_sample(e, cc);
         tests_run++;
         if (int'(state_o) != m_state || lock_o !== (m_state == 2) || int'(cc_span_o) != m_span()) begin
            tests_failed++;
            $display("FAIL random[%0d] got state=%0d lock=%0b span=%0d want %0d %0b %0d",
                     i, state_o, lock_o, cc_span_o, m_state, m_state == 2, m_span());
         end
         tests_run++;
         if (stall_o !== 1'b0 || int'(slip_count_o) != exp_slips()) begin
            tests_failed++;
            $display("FAIL random_aux[%0d] got stall=%0b slips=%0d want 0 %0d", i, stall_o, slip_count_o, exp_slips());
         end
      end
   endtask

   initial begin
      m_unlock();
      m_slips = 0;
      test_reset();
      test_lock_acquire();
      test_glitch_tolerance();
      test_slip();
      test_window_restart();
      test_timeout();
      test_saturation_enable();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
